// File: rtl/ppu_decode_stage.sv
// ppu_decode_stage: registered MIPS instruction-decode stage.
//   Decodes the IF/ID instruction into a packed control word, register
//   specifiers, resolved destination and extended immediate, all held in a
//   one-cycle output register. Adds a load-use interlock (one bubble),
//   EX backpressure, flush and a saturating illegal-instruction counter.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   if_valid, instr     instruction from IF/ID
//   ex_ready            EX accepts the held output this cycle
//   flush               drop the held output and the current input
//   id_stall            combinational: IF must hold instr and PC
//   id_valid            output register holds a real instruction
//   id_ctrl             {src_op[2:0], alu_op[3:0], b_instr, load, rf_en,
//                        ta_instr, mem_size[1:0], mem_rw, mem_se, mem_en,
//                        hi_en, lo_en}
//     src_op: 0 rs/rt, 1 rs/imm, 2 shamt/rt, 3 rs/zero (compare with zero),
//             4 link (write PC+8)
//   id_rs, id_rt        source specifiers
//   id_dest             resolved destination register
//   id_imm              extended immediate
//   id_illegal          unsupported encoding (control word all zero)
//   illegal_cnt         saturating count of issued illegal instructions
module ppu_decode_stage #(
  parameter int INSTR_W = 32,
  parameter int REG_W   = 5,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               if_valid,
  input  logic [INSTR_W-1:0] instr,
  input  logic               ex_ready,
  input  logic               flush,
  output logic               id_stall,
  output logic               id_valid,
  output logic [17:0]        id_ctrl,
  output logic [REG_W-1:0]   id_rs,
  output logic [REG_W-1:0]   id_rt,
  output logic [REG_W-1:0]   id_dest,
  output logic [31:0]        id_imm,
  output logic               id_illegal,
  output logic [CNT_W-1:0]   illegal_cnt
);

  typedef enum logic {RUN, INTERLOCK} state_t;

  localparam logic [2:0] SRC_REG   = 3'd0;
  localparam logic [2:0] SRC_IMM   = 3'd1;
  localparam logic [2:0] SRC_SHAMT = 3'd2;
  localparam logic [2:0] SRC_ZERO  = 3'd3;
  localparam logic [2:0] SRC_LINK  = 3'd4;

  state_t           state;
  logic             sb_valid;
  logic [REG_W-1:0] sb_dest;

  logic [5:0]       opcode, funct;
  logic [REG_W-1:0] f_rs, f_rt, f_rd;
  logic [15:0]      f_imm;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign f_rs   = instr[25:21];
  assign f_rt   = instr[20:16];
  assign f_rd   = instr[15:11];
  assign f_imm  = instr[15:0];

  logic [2:0]       d_src;
  logic [3:0]       d_alu;
  logic [1:0]       d_size;
  logic             d_b, d_load, d_wr, d_ta, d_rw, d_se, d_men;
  logic             d_illegal, d_use_rs, d_use_rt, d_zext, d_lui;
  logic [REG_W-1:0] d_dest_raw, d_dest;
  logic [17:0]      d_ctrl;
  logic [31:0]      d_imm;

  always_comb begin
    d_src = SRC_REG; d_alu = '0; d_size = '0;
    d_b = 1'b0; d_load = 1'b0; d_wr = 1'b0; d_ta = 1'b0;
    d_rw = 1'b0; d_se = 1'b0; d_men = 1'b0;
    d_illegal = 1'b0; d_use_rs = 1'b1; d_use_rt = 1'b0;
    d_zext = 1'b0; d_lui = 1'b0; d_dest_raw = '0;
    case (opcode)
      6'h00: begin
        d_dest_raw = f_rd; d_wr = 1'b1; d_use_rt = 1'b1;
        case (funct)
          6'h20: d_alu = 4'h0;
          6'h21: d_alu = 4'h1;
          6'h22: d_alu = 4'h2;
          6'h23: d_alu = 4'h3;
          6'h24: d_alu = 4'h4;
          6'h25: d_alu = 4'h5;
          6'h26: d_alu = 4'h6;
          6'h27: d_alu = 4'h7;
          6'h2A: d_alu = 4'h8;
          6'h2B: d_alu = 4'h9;
          6'h00: begin d_alu = 4'hB; d_src = SRC_SHAMT; d_use_rs = 1'b0; end
          6'h02: begin d_alu = 4'hC; d_src = SRC_SHAMT; d_use_rs = 1'b0; end
          6'h03: begin d_alu = 4'hD; d_src = SRC_SHAMT; d_use_rs = 1'b0; end
          6'h08: begin d_alu = 4'hE; d_ta = 1'b1; d_wr = 1'b0; d_use_rt = 1'b0; end
          6'h09: begin d_alu = 4'hE; d_ta = 1'b1; d_src = SRC_LINK; d_use_rt = 1'b0; end
          default: d_illegal = 1'b1;
        endcase
      end
      6'h01: begin
        d_alu = 4'h3; d_b = 1'b1; d_src = SRC_ZERO;
        case (f_rt)
          5'h00, 5'h01: ;
          5'h10, 5'h11: begin d_wr = 1'b1; d_dest_raw = REG_W'(31); d_src = SRC_LINK; end
          default:      d_illegal = 1'b1;
        endcase
      end
      6'h02: begin d_alu = 4'hE; d_ta = 1'b1; d_use_rs = 1'b0; end
      6'h03: begin
        d_alu = 4'hE; d_ta = 1'b1; d_use_rs = 1'b0;
        d_wr = 1'b1; d_dest_raw = REG_W'(31); d_src = SRC_LINK;
      end
      6'h04, 6'h05: begin d_alu = 4'h3; d_b = 1'b1; d_use_rt = 1'b1; end
      6'h06, 6'h07: begin d_alu = 4'h3; d_b = 1'b1; d_src = SRC_ZERO; end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        d_src = SRC_IMM; d_wr = 1'b1; d_dest_raw = f_rt;
        case (opcode[2:0])
          3'h0: d_alu = 4'h0;
          3'h1: d_alu = 4'h1;
          3'h2: d_alu = 4'h8;
          3'h3: d_alu = 4'h9;
          3'h4: begin d_alu = 4'h4; d_zext = 1'b1; end
          3'h5: begin d_alu = 4'h5; d_zext = 1'b1; end
          3'h6: begin d_alu = 4'h6; d_zext = 1'b1; end
          default: begin d_alu = 4'hA; d_lui = 1'b1; d_use_rs = 1'b0; end
        endcase
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        d_alu = 4'h1; d_src = SRC_IMM; d_load = 1'b1; d_wr = 1'b1;
        d_dest_raw = f_rt; d_men = 1'b1;
        case (opcode)
          6'h20:   begin d_size = 2'b00; d_se = 1'b1; end
          6'h21:   begin d_size = 2'b01; d_se = 1'b1; end
          6'h24:   d_size = 2'b00;
          6'h25:   d_size = 2'b01;
          default: d_size = 2'b10;
        endcase
      end
      6'h28, 6'h29, 6'h2B: begin
        d_alu = 4'h1; d_src = SRC_IMM; d_rw = 1'b1; d_men = 1'b1; d_use_rt = 1'b1;
        d_size = (opcode == 6'h28) ? 2'b00 : (opcode == 6'h29) ? 2'b01 : 2'b10;
      end
      default: d_illegal = 1'b1;
    endcase
    // An unsupported encoding reads rs only and drives no control at all.
    if (d_illegal) begin
      d_use_rs = 1'b1;
      d_use_rt = 1'b0;
    end
  end

  assign d_dest = d_illegal ? '0 : d_dest_raw;
  assign d_ctrl = d_illegal ? '0 :
                  {d_src, d_alu, d_b, d_load, d_wr && (d_dest != '0), d_ta,
                   d_size, d_rw, d_se, d_men, 2'b00};
  assign d_imm  = d_lui  ? {f_imm, 16'h0000} :
                  d_zext ? {16'h0000, f_imm} : {{16{f_imm[15]}}, f_imm};

  logic hazard, hold, adv, take;

  assign hazard = (state == RUN) && if_valid && sb_valid && (sb_dest != '0) &&
                  ((d_use_rs && (f_rs == sb_dest)) || (d_use_rt && (f_rt == sb_dest)));
  // Backpressure wins over a hazard; the hazard is re-evaluated once EX drains.
  assign hold     = id_valid && !ex_ready;
  assign id_stall = !reset && !flush && (hold || hazard);
  assign adv      = reset || flush || !hold;
  assign take     = !reset && !flush && !hold && !hazard && if_valid;

  always_ff @(posedge clk) begin
    if (adv) begin
      id_valid   <= take;
      id_ctrl    <= take ? d_ctrl : '0;
      id_rs      <= take ? f_rs   : '0;
      id_rt      <= take ? f_rt   : '0;
      id_dest    <= take ? d_dest : '0;
      id_imm     <= take ? d_imm  : '0;
      id_illegal <= take && d_illegal;
    end
    if (reset)
      illegal_cnt <= '0;
    else if (take && d_illegal && !(&illegal_cnt))
      illegal_cnt <= illegal_cnt + 1'b1;
    if (reset || flush) begin
      state    <= RUN;
      sb_valid <= 1'b0;
      sb_dest  <= '0;
    end else if (!hold) begin
      state    <= hazard ? INTERLOCK : RUN;
      sb_valid <= take && d_load && (d_dest != '0);
      sb_dest  <= d_dest;
    end
  end

endmodule

// File: doc/ppu_decode_stage.md
# ppu_decode_stage

Registered instruction-decode stage for the PPU pipeline. It sits between the IF/ID boundary and the EX stage and turns a 32-bit MIPS instruction into a packed control word, register specifiers and an extended immediate. It adds what a purely combinational decoder lacks: a one-cycle output register, a load-use interlock, a downstream backpressure handshake, flush, and a saturating illegal-instruction counter.

## Interface
- INSTR_W, 32, instruction width; only 32 is supported.
- REG_W, 5, register specifier width.
- CNT_W, 8, illegal-instruction counter width.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- if_valid  in  1  instr holds a valid instruction.
- instr  in  32  instruction from IF/ID.
- ex_ready  in  1  EX accepts the current output this cycle.
- flush  in  1  discard the held output and the current input.
- id_stall  out  1  combinational; IF must hold instr and PC.
- id_valid  out  1  the output register holds a real instruction.
- id_ctrl  out  18  {src_op[2:0], alu_op[3:0], b_instr, load, rf_en, ta_instr, mem_size[1:0], mem_rw, mem_se, mem_en, hi_en, lo_en}.
- id_rs, id_rt  out  REG_W  source specifiers (instr[25:21], instr[20:16]).
- id_dest  out  REG_W  resolved destination register.
- id_imm  out  32  extended immediate.
- id_illegal  out  1  unsupported encoding; all side-effect bits are 0.
- illegal_cnt  out  CNT_W  count of issued illegal instructions; saturates.

## Operation
- Supported instructions:
  - R-type: ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, JR, JALR.
  - I-type: ADDI, ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI, LB, LBU, LH, LHU, LW, SB, SH, SW, BEQ, BNE, BLEZ, BGTZ.
  - REGIMM: BLTZ, BGEZ, BLTZAL, BGEZAL.
  - Jumps: J, JAL.
  - Any other encoding sets id_illegal=1 with rf_en=mem_en=hi_en=lo_en=0.
- alu_op encoding: 0 ADD, 1 ADDU, 2 SUB, 3 SUBU, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 SLT, 9 SLTU, A LUI, B SLL, C SRL, D SRA, E pass-A.
  - Loads and stores use ADDU.
  - Branches use SUBU.
- mem_size: 00 byte, 01 half, 10 word.
  - mem_se=1 for LB and LH only.
  - mem_rw=1 for stores.
  - mem_en=1 for loads and stores.
- id_dest:
  - rd for R-type.
  - rt for I-type ALU ops and loads.
  - 31 for JAL, BLTZAL and BGEZAL.
  - rd for JALR.
  - If id_dest=0, rf_en is forced to 0.
- id_imm:
  - Zero-extended for ANDI, ORI, XORI.
  - {imm,16'h0} for LUI.
  - Sign-extended otherwise.
- b_instr=1 for all conditional branches; ta_instr=1 for J, JAL, JR, JALR.
- A bubble has id_valid=0 and id_ctrl=0.
- State machine: RUN, INTERLOCK.
  - Scoreboard: last_load_valid and last_load_dest, set when an issued instruction has load=1 and rf_en=1.
- Hazard condition:
  - State is RUN, if_valid=1 and last_load_valid=1.
  - last_load_dest≠0 and it equals a source the current instruction reads.
  - rs is read by all except J, JAL, LUI, SLL, SRL, SRA.
  - rt is read by R-type ALU ops, SLL, SRL, SRA, stores, BEQ and BNE.
- On a hazard:
  - id_stall=1.
  - A bubble is issued and the scoreboard is cleared.
  - Next state is INTERLOCK.
- INTERLOCK: the held instruction issues unconditionally (no re-check) and the next state is RUN.
- Backpressure:
  - ex_ready=0 and id_valid=1: outputs hold, id_stall=1, state and scoreboard frozen.
  - ex_ready=0 with a bubble held: a new instruction may load.
- flush=1 has priority over everything:
  - Next edge loads a bubble and clears the scoreboard.
  - State goes to RUN and the input is dropped.
  - id_stall=0.
- illegal_cnt increments when an illegal instruction is issued. It holds at 2^CNT_W−1.

## Timing
- Latency: 1 cycle from instr (if_valid=1, id_stall=0) to id_* outputs.
- id_stall is a combinational function of the current-cycle inputs and the registered state.
- A load-use pair costs exactly 1 bubble. A load followed by an independent instruction costs 0.
- Reset values: id_valid=0, id_ctrl=0, id_rs=id_rt=id_dest=0, id_imm=0, id_illegal=0, illegal_cnt=0, state RUN, scoreboard cleared. id_stall=0 while reset is asserted.
- Reset or flush during INTERLOCK abandons the held instruction; IF refetches it.
- A simultaneous hazard and ex_ready=0 is treated as backpressure only; the hazard is re-evaluated once ex_ready=1.

## Test plan
- ADDIU $5,$0,0xFFFF (0x2405FFFF) → next cycle: id_valid=1, alu_op=1, id_dest=5, id_imm=0xFFFFFFFF, rf_en=1.
- LW $2,0($1) then ADDU $3,$2,$4 → ADDU cycle id_stall=1; bubble issued; ADDU issued one cycle later with id_dest=3.
- LW $2,0($1) then ADDU $3,$5,$4 → no stall; back-to-back issue.
- JAL 0x100 → id_dest=31, ta_instr=1, rf_en=1. ORI $0,$0,1 → rf_en=0.
- ex_ready=0 for 3 cycles with SW held → outputs stable and id_stall=1 throughout. flush asserted in the 2nd cycle → bubble on the next edge.
- 260 consecutive opcode-0x3F words (CNT_W=8) → illegal_cnt reaches 255 and holds. reset mid-sequence → 0 on the next edge.
